// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: MIPS instruction-fetch stage with PC register, IF/ID
// pipeline register and a two-state (RUN/ISR) interrupt controller.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-low reset
//   interrupt       level-sensitive interrupt request
//   stall           hazard-unit hold for PC and IF/ID
//   branch_taken    EX-stage redirect request
//   branch_target   redirect address (16-bit word address)
//   eret            return-from-interrupt from ID
//   imem_data       combinational instruction-memory read data
//   imem_addr       fetch address (the PC register)
//   ins             IF/ID instruction
//   Current_Address IF/ID PC of ins
//   valid           ins is a real fetched instruction (0 for inserted NOP)
//   epc             saved return address
//   int_active      1 while in ISR
module mips_fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] INT_VECTOR = 16'h0040,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        eret,
    input  logic [31:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [31:0] ins,
    output logic [15:0] Current_Address,
    output logic        valid,
    output logic [15:0] epc,
    output logic        int_active
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    typedef enum logic {
        RUN = 1'b0,
        ISR = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   ins_q, ins_d;
    logic [AW-1:0]   ca_q, ca_d;
    logic            valid_q, valid_d;
    logic [AW-1:0]   epc_q, epc_d;

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            ca_q    <= '0;
            valid_q <= 1'b0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            ca_q    <= ca_d;
            valid_q <= valid_d;
            epc_q   <= epc_d;
        end
    end

    // Next-state: branch > interrupt entry > eret > stall > sequential fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        ca_d    = ca_q;
        valid_d = valid_q;
        epc_d   = epc_q;

        if (branch_taken) begin
            pc_d    = branch_target;
            ins_d   = NOP_WORD;
            valid_d = 1'b0;
            ca_d    = pc_q;
        end else if (state_q == RUN && interrupt && !stall) begin
            // Instruction at pc is dropped and refetched after eret
            epc_d   = pc_q;
            pc_d    = INT_VECTOR;
            ins_d   = NOP_WORD;
            valid_d = 1'b0;
            state_d = ISR;
        end else if (state_q == ISR && eret && !stall) begin
            pc_d    = epc_q;
            ins_d   = NOP_WORD;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (!stall) begin
            pc_d    = AW'(pc_q + AW'(1));
            ins_d   = imem_data;
            ca_d    = pc_q;
            valid_d = 1'b1;
        end
    end

    assign imem_addr       = pc_q;
    assign ins             = ins_q;
    assign Current_Address = ca_q;
    assign valid           = valid_q;
    assign epc             = epc_q;
    assign int_active      = (state_q == ISR);

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage with a spec-level reference model.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        eret;
    logic [31:0] imem_data;
    logic [15:0] imem_addr;
    logic [31:0] ins;
    logic [15:0] Current_Address;
    logic        valid;
    logic [15:0] epc;
    logic        int_active;

    int tests = 0;
    int fails = 0;

    mips_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .interrupt       (interrupt),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .eret            (eret),
        .imem_data       (imem_data),
        .imem_addr       (imem_addr),
        .ins             (ins),
        .Current_Address (Current_Address),
        .valid           (valid),
        .epc             (epc),
        .int_active      (int_active)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address A is 32'h1000_0000 + A
    assign imem_data = 32'h1000_0000 + {16'h0000, imem_addr};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state stepped by the priority rules
    logic        m_started = 1'b0;
    logic        m_isr;
    logic [15:0] m_pc, m_ca, m_epc;
    logic [31:0] m_ins;
    logic        m_valid;

    always @(posedge clk) begin
        if (!reset) begin
            m_started <= 1'b1;
            m_isr     <= 1'b0;
            m_pc      <= 16'h0000;
            m_ins     <= 32'h0;
            m_ca      <= 16'h0;
            m_valid   <= 1'b0;
            m_epc     <= 16'h0;
        end else if (m_started) begin
            if (branch_taken) begin
                m_pc    <= branch_target;
                m_ins   <= 32'h0;
                m_valid <= 1'b0;
                m_ca    <= m_pc;
            end else if (!m_isr && interrupt && !stall) begin
                m_epc   <= m_pc;
                m_pc    <= 16'h0040;
                m_ins   <= 32'h0;
                m_valid <= 1'b0;
                m_isr   <= 1'b1;
            end else if (m_isr && eret && !stall) begin
                m_pc    <= m_epc;
                m_ins   <= 32'h0;
                m_valid <= 1'b0;
                m_isr   <= 1'b0;
            end else if (!stall) begin
                m_pc    <= m_pc + 16'd1;
                m_ins   <= 32'h1000_0000 + {16'h0000, m_pc};
                m_ca    <= m_pc;
                m_valid <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_started) begin
            chk("model_imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("model_ins", ins, m_ins);
            chk("model_ca", 32'(Current_Address), 32'(m_ca));
            chk("model_valid", 32'(valid), 32'(m_valid));
            chk("model_epc", 32'(epc), 32'(m_epc));
            chk("model_int_active", 32'(int_active), 32'(m_isr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // {branch_taken, interrupt, stall, eret}
    logic [3:0] vec [20] = '{4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b0011,
                             4'b0001, 4'b0100, 4'b1100, 4'b0110, 4'b0100,
                             4'b0010, 4'b1010, 4'b0001, 4'b0000, 4'b1001,
                             4'b0101, 4'b0000, 4'b0010, 4'b0001, 4'b0000};

    initial begin
        reset = 1'b0; interrupt = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0; eret = 1'b0;

        // Reset for two edges
        cyc(); cyc();
        chk("rst_int_active", 32'(int_active), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_epc", 32'(epc), 32'h0);
        chk("rst_ins", ins, 32'h0);
        reset = 1'b1;
        cyc();
        chk("f0_ca", 32'(Current_Address), 32'h0);
        chk("f0_ins", ins, 32'h1000_0000);
        chk("f0_valid", 32'(valid), 32'h1);
        cyc();
        chk("f1_ca", 32'(Current_Address), 32'h1);
        cyc();
        chk("f2_ca", 32'(Current_Address), 32'h2);
        chk("f2_ins", ins, 32'h1000_0002);
        cyc(); cyc();
        chk("pc5", 32'(imem_addr), 32'h5);

        // Branch flush
        branch_taken = 1'b1; branch_target = 16'h0020;
        cyc();
        chk("br_valid", 32'(valid), 32'h0);
        chk("br_ins", ins, 32'h0);
        chk("br_ca", 32'(Current_Address), 32'h5);
        chk("br_pc", 32'(imem_addr), 32'h20);
        branch_taken = 1'b0;
        cyc();
        chk("br_tgt_ca", 32'(Current_Address), 32'h20);
        chk("br_tgt_valid", 32'(valid), 32'h1);

        // Interrupt entry at pc=8 and return
        branch_taken = 1'b1; branch_target = 16'h0008;
        cyc();
        branch_taken = 1'b0; interrupt = 1'b1;
        cyc();
        chk("irq_epc", 32'(epc), 32'h8);
        chk("irq_active", 32'(int_active), 32'h1);
        chk("irq_pc", 32'(imem_addr), 32'h40);
        chk("irq_valid", 32'(valid), 32'h0);
        interrupt = 1'b0;
        cyc();
        chk("isr_fetch_ca", 32'(Current_Address), 32'h40);
        eret = 1'b1;
        cyc();
        chk("eret_pc", 32'(imem_addr), 32'h8);
        chk("eret_active", 32'(int_active), 32'h0);
        eret = 1'b0;
        cyc();
        chk("eret_ca", 32'(Current_Address), 32'h8);
        chk("eret_ins", ins, 32'h1000_0008);

        // Interrupt deferred by stall
        interrupt = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", 32'(imem_addr), 32'h9);
            chk("stall_active", 32'(int_active), 32'h0);
            chk("stall_ins", ins, 32'h1000_0008);
        end
        stall = 1'b0;
        cyc();
        chk("defer_epc", 32'(epc), 32'h9);
        chk("defer_active", 32'(int_active), 32'h1);

        // eret deferred by stall, then eret with interrupt held
        eret = 1'b1; stall = 1'b1;
        cyc();
        chk("eret_stall_active", 32'(int_active), 32'h1);
        stall = 1'b0;
        cyc();
        chk("eret_irq_active", 32'(int_active), 32'h0);
        chk("eret_irq_pc", 32'(imem_addr), 32'h9);
        eret = 1'b0;
        cyc();
        chk("reenter_active", 32'(int_active), 32'h1);
        chk("reenter_epc", 32'(epc), 32'h9);
        interrupt = 1'b0;

        // Branch inside ISR keeps state and epc
        branch_taken = 1'b1; branch_target = 16'h0100;
        cyc();
        chk("isr_br_active", 32'(int_active), 32'h1);
        chk("isr_br_pc", 32'(imem_addr), 32'h100);
        branch_taken = 1'b0; eret = 1'b1;
        cyc();
        eret = 1'b0;

        // Branch beats interrupt; PC wrap
        branch_taken = 1'b1; branch_target = 16'hFFFF; interrupt = 1'b1;
        cyc();
        chk("br_irq_active", 32'(int_active), 32'h0);
        branch_taken = 1'b0; interrupt = 1'b0;
        cyc();
        chk("wrap_pc", 32'(imem_addr), 32'h0);
        chk("wrap_ca", 32'(Current_Address), 32'hFFFF);
        chk("wrap_ins", ins, 32'h1000_FFFF);

        // Reset inside ISR with interrupt held
        branch_taken = 1'b1; branch_target = 16'h0030; interrupt = 1'b1;
        cyc();
        branch_taken = 1'b0;
        cyc();
        chk("pre_rst_active", 32'(int_active), 32'h1);
        reset = 1'b0;
        cyc();
        chk("isr_rst_active", 32'(int_active), 32'h0);
        chk("isr_rst_epc", 32'(epc), 32'h0);
        chk("isr_rst_pc", 32'(imem_addr), 32'h0);
        reset = 1'b1;
        cyc();
        chk("post_rst_active", 32'(int_active), 32'h1);
        interrupt = 1'b0; eret = 1'b1;
        cyc();

        // eret in RUN is ignored
        cyc();
        chk("eret_run_ca", 32'(Current_Address), 32'h0);
        chk("eret_run_valid", 32'(valid), 32'h1);
        eret = 1'b0;

        // Branch during stall
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0055;
        cyc();
        chk("stall_br_pc", 32'(imem_addr), 32'h55);
        branch_taken = 1'b0;
        cyc();
        chk("stall_br_hold", 32'(imem_addr), 32'h55);
        stall = 1'b0;

        // Mixed directed vectors checked by the model
        for (int i = 0; i < 20; i++) begin
            {branch_taken, interrupt, stall, eret} = vec[i];
            branch_target = 16'(i * 7 + 3);
            cyc();
        end
        {branch_taken, interrupt, stall, eret} = 4'b0000;
        cyc(); cyc();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
